// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop input synchroniser, centre-sampling FSM,
// optional parity, 1..2 stop bits, held output with valid/ready handshake.
module uart_rx_param #(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx_param: CLK_HZ/BAUD must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  // Odd parity wants an odd count of ones across payload and parity bit.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] payload,
                                      input logic sample);
    logic x;
    x = (^payload) ^ sample;
    if (PARITY == 1)      parity_bad = ~x;
    else if (PARITY == 2) parity_bad = x;
    else                  parity_bad = 1'b0;
  endfunction

  logic                 rx_p0, rx_p1, rxs;
  state_t               state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 perr_q, perr_n, ferr_q, ferr_n;
  logic                 baud_zero, stop_err, done;

  // Stage p0/p1: synchronise the asynchronous line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end
  assign rxs = rx_p1;

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      perr_q    <= perr_n;
      ferr_q    <= ferr_n;
    end
  end

  assign baud_zero = (baud_cnt == '0);
  assign stop_err  = ferr_q | ~rxs;

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    perr_n  = perr_q;
    ferr_n  = ferr_q;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          baud_n  = HALF_LOAD;
          bit_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      START: begin
        if (baud_zero) begin
          // A start bit that is high again at its centre was only a glitch.
          if (!rxs) begin
            state_n = DATA;
            baud_n  = BIT_LOAD;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - BW'(1);
        end
      end
      DATA: begin
        if (baud_zero) begin
          shift_n = {rxs, shift_reg[DATA_BITS-1:1]};
          baud_n  = BIT_LOAD;
          if (bit_cnt == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          baud_n = baud_cnt - BW'(1);
        end
      end
      PAR: begin
        if (baud_zero) begin
          perr_n  = parity_bad(shift_reg, rxs);
          baud_n  = BIT_LOAD;
          bit_n   = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt - BW'(1);
        end
      end
      STOP: begin
        if (baud_zero) begin
          ferr_n = stop_err;
          if (bit_cnt == LAST_STOP) begin
            done    = 1'b1;
            baud_n  = '0;
            bit_n   = '0;
            state_n = stop_err ? BREAK : IDLE;
          end else begin
            bit_n  = bit_cnt + 4'd1;
            baud_n = BIT_LOAD;
          end
        end else begin
          baud_n = baud_cnt - BW'(1);
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is accepted.
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output holding register and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data       <= shift_reg;
          parity_err <= (PARITY != 0) ? perr_q : 1'b0;
          frame_err  <= stop_err;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
